// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter:
// RAM control bit positions, FSM states and owner codes.
package ram_port_arbiter_pkg;

   localparam int RAM_CS_BIT = 1;
   localparam int RAM_WE_BIT = 0;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner selection between core and
// debug requests (fixed priority with starvation limit, or RR).
module ram_arb_select
   import ram_port_arbiter_pkg::*;
#(
   parameter int CORE_PRIO = 1,
   parameter int MAX_WAIT  = 3
) (
   input  logic       c_req_i,
   input  logic       d_req_i,
   input  logic [2:0] starve_i,
   input  logic       last_own_i,
   output logic       win_valid_o,
   output logic       win_dbg_o
);

   localparam logic [2:0] MAX_W = 3'(MAX_WAIT);

   // Pick the winner; a lone request always wins
   always_comb begin
      win_valid_o = c_req_i | d_req_i;
      win_dbg_o   = OWN_CORE;
      if (c_req_i && d_req_i) begin
         if (CORE_PRIO != 0)
            win_dbg_o = (starve_i >= MAX_W);
         else
            win_dbg_o = (last_own_i == OWN_CORE);
      end else begin
         win_dbg_o = d_req_i;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single 16x4 RAM port between the core and the
// debug loader; sequences IDLE -> ISSUE (-> RESP) per access.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int CORE_PRIO = 1,
   parameter int MAX_WAIT  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       c_req,
   input  logic       d_req,
   input  logic       c_we,
   input  logic       d_we,
   input  logic [3:0] c_addr,
   input  logic [3:0] d_addr,
   input  logic [3:0] c_wdata,
   input  logic [3:0] d_wdata,
   output logic       c_gnt,
   output logic       d_gnt,
   output logic       c_rvalid,
   output logic       d_rvalid,
   output logic [3:0] c_rdata,
   output logic [3:0] d_rdata,
   output logic [3:0] ram_addr,
   output logic [3:0] ram_data_in,
   output logic [1:0] ram_crtl,
   input  logic [3:0] ram_data_out,
   output logic       owner
);

   arb_state_e state_q;
   logic [2:0] starve_q, starve_d;
   logic       last_q;
   logic       own_q;
   logic       c_gnt_q, d_gnt_q;
   logic       c_rv_q, d_rv_q;
   logic [3:0] c_rdata_q, d_rdata_q;
   logic [3:0] addr_q, din_q;
   logic [1:0] crtl_q;
   logic       win_valid, win_dbg;

   ram_arb_select #(
      .CORE_PRIO(CORE_PRIO),
      .MAX_WAIT (MAX_WAIT)
   ) u_sel (
      .c_req_i    (c_req),
      .d_req_i    (d_req),
      .starve_i   (starve_q),
      .last_own_i (last_q),
      .win_valid_o(win_valid),
      .win_dbg_o  (win_dbg)
   );

   // Starvation count: core grants taken while debug waits
   always_comb begin
      starve_d = starve_q;
      if (!d_req) begin
         starve_d = '0;
      end else if (state_q == ARB_IDLE && win_valid) begin
         if (win_dbg)
            starve_d = '0;
         else if (starve_q != 3'd7)
            starve_d = starve_q + 3'd1;
      end
   end

   // Transaction FSM with registered grant, RAM and read outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         starve_q  <= '0;
         last_q    <= OWN_DBG;
         own_q     <= OWN_CORE;
         c_gnt_q   <= 1'b0;
         d_gnt_q   <= 1'b0;
         c_rv_q    <= 1'b0;
         d_rv_q    <= 1'b0;
         c_rdata_q <= '0;
         d_rdata_q <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         crtl_q    <= 2'b00;
      end else begin
         c_gnt_q  <= 1'b0;
         d_gnt_q  <= 1'b0;
         c_rv_q   <= 1'b0;
         d_rv_q   <= 1'b0;
         crtl_q   <= 2'b00;
         starve_q <= starve_d;
         unique case (state_q)
            ARB_IDLE: begin
               if (win_valid) begin
                  own_q  <= win_dbg;
                  last_q <= win_dbg;
                  crtl_q[RAM_CS_BIT] <= 1'b1;
                  crtl_q[RAM_WE_BIT] <= win_dbg ? d_we : c_we;
                  addr_q  <= win_dbg ? d_addr : c_addr;
                  din_q   <= win_dbg ? d_wdata : c_wdata;
                  c_gnt_q <= ~win_dbg;
                  d_gnt_q <= win_dbg;
                  state_q <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               state_q <= crtl_q[RAM_WE_BIT] ? ARB_IDLE : ARB_RESP;
            end
            ARB_RESP: begin
               if (own_q == OWN_DBG) begin
                  d_rdata_q <= ram_data_out;
                  d_rv_q    <= 1'b1;
               end else begin
                  c_rdata_q <= ram_data_out;
                  c_rv_q    <= 1'b1;
               end
               state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign c_gnt       = c_gnt_q;
   assign d_gnt       = d_gnt_q;
   assign c_rvalid    = c_rv_q;
   assign d_rvalid    = d_rv_q;
   assign c_rdata     = c_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign ram_addr    = addr_q;
   assign ram_data_in = din_q;
   assign ram_crtl    = crtl_q;
   assign owner       = own_q;

endmodule
